// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: write-pointer synchronizer,
// binary/Gray read pointer, and registered empty/almost-empty/level/underflow flags.
module fifo_rd_ctrl #(
   parameter int DEPTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int AE_LEVEL    = 2,
   localparam int A          = $clog2(DEPTH)
) (
   input  logic         R_CLK,
   input  logic         R_RST,
   input  logic         R_INC,
   input  logic [A:0]   gray_Wptr,
   output logic         REMPTY,
   output logic         RALMOST_EMPTY,
   output logic [A:0]   R_LEVEL,
   output logic         R_UNDERFLOW,
   output logic [A-1:0] Raddr,
   output logic [A:0]   gray_Rptr
);

   localparam logic [A:0] AE_THRESH = (A+1)'(AE_LEVEL);

   logic [SYNC_STAGES-1:0][A:0] sync_q;
   logic [A:0] wq;
   logic [A:0] wbin;
   logic [A:0] rbin_q, rbin_d;
   logic [A:0] rgray_d;
   logic [A:0] level_d;
   logic       accept;
   logic       empty_q, almost_empty_q, underflow_q;
   logic [A:0] level_q, rgray_q;

   function automatic logic [A:0] gray2bin(input logic [A:0] g);
      logic [A:0] b;
      b[A] = g[A];
      for (int i = A - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign wq = sync_q[SYNC_STAGES-1];
   assign wbin = gray2bin(wq);

   // Flags are computed from the post-read pointer so an emptying read and a
   // freshly synchronized write on the same edge resolve in one step.
   assign accept  = R_INC && !empty_q;
   assign rbin_d  = rbin_q + {{A{1'b0}}, accept};
   assign rgray_d = rbin_d ^ (rbin_d >> 1);
   assign level_d = wbin - rbin_d;

   always_ff @(posedge R_CLK) begin
      if (R_RST) begin
         sync_q         <= '0;
         rbin_q         <= '0;
         rgray_q        <= '0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         level_q        <= '0;
         underflow_q    <= 1'b0;
      end else begin
         sync_q         <= {sync_q[SYNC_STAGES-2:0], gray_Wptr};
         rbin_q         <= rbin_d;
         rgray_q        <= rgray_d;
         empty_q        <= (rgray_d == wq);
         almost_empty_q <= (level_d <= AE_THRESH);
         level_q        <= level_d;
         underflow_q    <= R_INC && empty_q;
      end
   end

   assign Raddr         = rbin_q[A-1:0];
   assign gray_Rptr     = rgray_q;
   assign REMPTY        = empty_q;
   assign RALMOST_EMPTY = almost_empty_q;
   assign R_LEVEL       = level_q;
   assign R_UNDERFLOW   = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus random traffic, checked
// every cycle against a count-based reference of the read side.
module tb_fifo_rd_ctrl;

   localparam int DEPTH = 16;
   localparam int SYNC  = 2;
   localparam int AE    = 2;
   localparam int A     = 4;
   localparam int MOD   = 2 * DEPTH;

   logic         clk = 1'b0;
   logic         rst;
   logic         rinc;
   logic [A:0]   gwptr;
   logic         rempty, rae, runder;
   logic [A:0]   rlevel, grptr;
   logic [A-1:0] raddr;

   int total = 0;
   int bad   = 0;

   // Reference: read count, write counts seen by the read side after SYNC edges.
   int m_rd, m_level, m_empty, m_ae, m_under;
   int hist[$];

   fifo_rd_ctrl #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .AE_LEVEL(AE)) dut (
      .R_CLK(clk), .R_RST(rst), .R_INC(rinc), .gray_Wptr(gwptr),
      .REMPTY(rempty), .RALMOST_EMPTY(rae), .R_LEVEL(rlevel),
      .R_UNDERFLOW(runder), .Raddr(raddr), .gray_Rptr(grptr)
   );

   always #5 clk = ~clk;

   function automatic int to_gray(input int b);
      return (b ^ (b >> 1)) & (MOD - 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit r, input bit inc, input int wb);
      int seen;
      int accept;
      rst   = r;
      rinc  = inc;
      gwptr = (A+1)'(to_gray(wb));
      @(posedge clk);
      if (r) begin
         m_rd = 0; m_level = 0; m_empty = 1; m_ae = 1; m_under = 0;
         hist.delete();
         for (int i = 0; i < SYNC; i++) hist.push_back(0);
      end else begin
         accept  = (inc && m_empty == 0) ? 1 : 0;
         m_under = (inc && m_empty == 1) ? 1 : 0;
         m_rd    = (m_rd + accept) % MOD;
         seen    = hist.pop_front();
         hist.push_back(wb % MOD);
         m_level = (seen - m_rd) & (MOD - 1);
         m_empty = (m_level == 0) ? 1 : 0;
         m_ae    = (m_level <= AE) ? 1 : 0;
      end
      @(negedge clk);
      check("empty", 32'(rempty), 32'(m_empty));
      check("almost_empty", 32'(rae), 32'(m_ae));
      check("level", 32'(rlevel), 32'(m_level));
      check("underflow", 32'(runder), 32'(m_under));
      check("raddr", 32'(raddr), 32'(m_rd % DEPTH));
      check("gray_rptr", 32'(grptr), 32'(to_gray(m_rd)));
   endtask

   initial begin
      int wb;
      int prev_addr;
      rst = 1'b1; rinc = 1'b0; gwptr = '0;
      @(negedge clk);

      // Reset state
      cycle(1, 0, 0);
      check("rst_empty", 32'(rempty), 32'd1);
      check("rst_level", 32'(rlevel), 32'd0);

      // Three words arrive, then three reads drain them
      for (int i = 0; i < 3; i++) cycle(0, 0, 3);
      check("fill3_level", 32'(rlevel), 32'd3);
      check("fill3_empty", 32'(rempty), 32'd0);
      check("fill3_ae", 32'(rae), 32'd0);
      cycle(0, 1, 3);
      check("rd1_addr", 32'(raddr), 32'd1);
      check("rd1_ae", 32'(rae), 32'd1);
      cycle(0, 1, 3);
      check("rd2_addr", 32'(raddr), 32'd2);
      cycle(0, 1, 3);
      check("rd3_addr", 32'(raddr), 32'd3);
      check("rd3_empty", 32'(rempty), 32'd1);
      check("rd3_gray", 32'(grptr), 32'b00010);

      // Read while empty pulses underflow for one cycle only
      cycle(0, 1, 3);
      check("uf_pulse", 32'(runder), 32'd1);
      check("uf_addr", 32'(raddr), 32'd3);
      cycle(0, 0, 3);
      check("uf_clear", 32'(runder), 32'd0);

      // Full FIFO: level DEPTH is not empty; DEPTH reads wrap the MSB
      cycle(1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 16);
      check("full_level", 32'(rlevel), 32'd16);
      check("full_empty", 32'(rempty), 32'd0);
      for (int i = 0; i < 16; i++) cycle(0, 1, 16);
      check("wrap_gray", 32'(grptr), 32'b11000);
      check("wrap_addr", 32'(raddr), 32'd0);
      check("wrap_empty", 32'(rempty), 32'd1);

      // Reset mid-operation with a read pending
      cycle(1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 5);
      check("pre_rst_level", 32'(rlevel), 32'd5);
      cycle(1, 1, 5);
      check("mid_rst_level", 32'(rlevel), 32'd0);
      check("mid_rst_uf", 32'(runder), 32'd0);
      check("mid_rst_empty", 32'(rempty), 32'd1);
      cycle(0, 0, 5);
      cycle(0, 0, 5);
      check("rel2_empty", 32'(rempty), 32'd1);
      cycle(0, 0, 5);
      check("rel3_empty", 32'(rempty), 32'd0);

      // Streaming: one write and one read per cycle, crossing the pointer wrap
      cycle(1, 0, 0);
      wb = 3;
      for (int i = 0; i < 3; i++) cycle(0, 0, wb);
      for (int i = 0; i < 40; i++) begin
         prev_addr = int'(raddr);
         wb = (wb + 1) % MOD;
         cycle(0, 1, wb);
         check("stream_step", 32'(raddr), 32'((prev_addr + 1) % DEPTH));
         if (i >= 1) check("stream_nonempty", 32'(rempty), 32'd0);
         check("stream_no_uf", 32'(runder), 32'd0);
      end

      // Random traffic with occasional reset; writer never exceeds DEPTH ahead
      cycle(1, 0, 0);
      wb = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            wb = 0;
            cycle(1, 1'($urandom_range(0, 1)), wb);
         end else begin
            if ($urandom_range(0, 2) != 0 && (((wb + 1) - m_rd) & (MOD - 1)) <= DEPTH)
               wb = (wb + 1) % MOD;
            cycle(0, 1'($urandom_range(0, 1)), wb);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO word count (power of two, >=4); A = clog2(DEPTH).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning write-pointer synchronizer depth (legal 2..4).
REQ-003 SHALL have parameter AE_LEVEL, default 2, meaning almost-empty threshold in words (0..DEPTH-1).
REQ-004 SHALL have port R_CLK  in  1  read-domain clock; the single clock of the block.
REQ-005 SHALL have port R_RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port R_INC  in  1  read request; one word consumed per cycle when accepted.
REQ-007 SHALL have port gray_Wptr  in  A+1  Gray-coded write pointer, asynchronous to R_CLK.
REQ-008 SHALL have port REMPTY  out  1  FIFO empty, registered.
REQ-009 SHALL have port RALMOST_EMPTY  out  1  occupancy <= AE_LEVEL, registered.
REQ-010 SHALL have port R_LEVEL  out  A+1  words available, registered, 0..DEPTH.
REQ-011 SHALL have port R_UNDERFLOW  out  1  one-cycle pulse: read attempted while empty.
REQ-012 SHALL have port Raddr  out  A  RAM read address.
REQ-013 SHALL have port gray_Rptr  out  A+1  Gray-coded read pointer for the write domain, registered.

Function
REQ-014 SHALL pass gray_Wptr through SYNC_STAGES flops on R_CLK; only the last stage (wq) is used by downstream logic.
REQ-015 SHALL convert wq to binary generically for any A: b[A]=g[A], b[i]=b[i+1]^g[i]; no lookup tables.
REQ-016 SHALL hold binary read pointer rbin, A+1 bits; accept = R_INC && !REMPTY; rbin_next = rbin+accept, wrapping modulo 2^(A+1).
REQ-017 SHALL drive Raddr = rbin[A-1:0], combinational from rbin, no reset gating.
REQ-018 SHALL register gray_Rptr <= rbin_next ^ (rbin_next>>1) on the same edge rbin updates (zero lag between rbin and gray_Rptr).
REQ-019 SHALL register REMPTY <= (gray(rbin_next) == wq), full A+1-bit compare; the accepting read that empties the FIFO sets REMPTY on the same edge.
REQ-020 SHALL register R_LEVEL <= (bin(wq) - rbin_next) modulo 2^(A+1).
REQ-021 SHALL register RALMOST_EMPTY <= (R_LEVEL next value <= AE_LEVEL).
REQ-022 SHALL register R_UNDERFLOW <= R_INC && REMPTY; rbin, Raddr, gray_Rptr SHALL NOT change on such a request.
REQ-023 Latency: a gray_Wptr change stable before edge 1 SHALL be reflected in REMPTY/R_LEVEL/RALMOST_EMPTY after edge SYNC_STAGES+1.
REQ-024 Simultaneous read accept and synchronized write arrival on one edge SHALL yield flags computed from both new values (no intermediate state).
REQ-025 Wrap: every DEPTH accepted reads SHALL toggle rbin[A]; empty requires all A+1 bits equal, so level DEPTH (pointers differ only in MSB) SHALL read as not empty.

Reset
REQ-026 On R_RST high at an R_CLK edge: rbin=0, synchronizer stages=0, gray_Rptr=0, Raddr=0, REMPTY=1, RALMOST_EMPTY=1, R_LEVEL=0, R_UNDERFLOW=0.
REQ-027 R_RST SHALL override R_INC; after release, flags SHALL track gray_Wptr only after SYNC_STAGES+1 edges.
REQ-028 Reset mid-operation SHALL discard outstanding occupancy; no underflow pulse SHALL be generated by reads during reset.

Verification (DEPTH=16, SYNC_STAGES=2, AE_LEVEL=2)
REQ-029 Reset 1 cycle -> REMPTY=1, RALMOST_EMPTY=1, R_LEVEL=0, Raddr=0, gray_Rptr=0, R_UNDERFLOW=0.
REQ-030 gray_Wptr=5'b00010 (bin 3), no reads -> after 3rd edge REMPTY=0, R_LEVEL=3, RALMOST_EMPTY=0; then 3 reads -> Raddr 1,2,3, RALMOST_EMPTY=1 after first read, REMPTY=1 after third, gray_Rptr=5'b00010.
REQ-031 R_INC=1 while REMPTY=1 -> Raddr unchanged, R_UNDERFLOW=1 for exactly one cycle.
REQ-032 gray_Wptr=5'b11000 (bin 16) from rbin=0 -> R_LEVEL=16, REMPTY=0; 16 reads -> rbin=16, Raddr=0, gray_Rptr=5'b11000, REMPTY=1.
REQ-033 R_RST asserted with R_LEVEL=5 and R_INC=1 -> next edge all REQ-026 values, R_UNDERFLOW=0; REMPTY deasserts again 3 edges after release.
REQ-034 Back-to-back reads with a gray_Wptr increment each cycle at level 1 -> REMPTY never asserts once level has stabilized, no underflow, Raddr increments by 1 every cycle.
